// File: rtl/icache_responder_pkg.sv
// Shared types for the direct-mapped one-word instruction cache responder:
// the datapath word, frame layout and controller state encoding.
package icache_responder_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;
  localparam int WADDR_W    = WORD_W - BYTE_OFF_W;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } icache_state_t;

  // Tag is held at the widest possible size; the top bits stay zero for larger SETS.
  typedef struct packed {
    logic                 valid;
    logic [WADDR_W-1:0]   tag;
    word_t                data;
  } icache_frame_t;

  function automatic word_t word_align(input word_t addr);
    return {addr[WORD_W-1:BYTE_OFF_W], {BYTE_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_responder_if.sv
// Datapath-side and memory-side signals of the instruction cache responder,
// bundled so the cache and its environment share one connection.
interface icache_responder_if #(
  parameter int CNT_W = 16
) ();
  import icache_responder_pkg::*;

  logic             imemREN;
  word_t            imemaddr;
  logic             ihit;
  word_t            imemload;
  logic             flush;
  logic             iREN;
  word_t            iaddr;
  logic             iwait;
  word_t            iload;
  logic [CNT_W-1:0] miss_count;

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr, miss_count
  );

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr, miss_count
  );

endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-frame instruction cache with zero-cycle hits
// and a single outstanding fill to memory.
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  icache_responder_if.slave bus
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WADDR_W - IDX_W;

  icache_state_t      state_q, state_d;
  logic [SETS-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [SETS];
  word_t              data_q [SETS];
  word_t              miss_addr_q, miss_addr_d;
  logic [CNT_W-1:0]   miss_count_q, miss_count_d;

  logic [IDX_W-1:0]   req_idx, miss_idx;
  logic [TAG_W-1:0]   req_tag, miss_tag;
  icache_frame_t      cur_frame;
  logic               hit;
  logic               fill_en;
  logic               ihit;
  word_t              imemload;
  logic               iren;
  word_t              iaddr;
  logic               unused_low_bits;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign req_idx  = bus.imemaddr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
  assign req_tag  = bus.imemaddr[WORD_W-1:IDX_W+BYTE_OFF_W];
  assign miss_idx = miss_addr_q[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
  assign miss_tag = miss_addr_q[WORD_W-1:IDX_W+BYTE_OFF_W];

  assign unused_low_bits = ^{bus.imemaddr[BYTE_OFF_W-1:0], miss_addr_q[BYTE_OFF_W-1:0]};

  always_comb begin
    cur_frame.valid = valid_q[req_idx];
    cur_frame.tag   = {{IDX_W{1'b0}}, tag_q[req_idx]};
    cur_frame.data  = data_q[req_idx];
  end

  assign hit = bus.imemREN && cur_frame.valid &&
               (cur_frame.tag == {{IDX_W{1'b0}}, req_tag});

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    miss_addr_d  = miss_addr_q;
    miss_count_d = miss_count_q;
    fill_en      = 1'b0;
    ihit         = 1'b0;
    imemload     = '0;
    iren         = 1'b0;
    iaddr        = '0;

    unique case (state_q)
      IDLE: begin
        // A flush in the same cycle suppresses both the hit and a new miss.
        if (hit && !bus.flush) begin
          ihit     = 1'b1;
          imemload = cur_frame.data;
        end
        if (bus.imemREN && !hit && !bus.flush) begin
          miss_addr_d = word_align(bus.imemaddr);
          state_d     = MISS;
        end
      end
      MISS: begin
        iren  = 1'b1;
        iaddr = miss_addr_q;
        if (bus.flush) begin
          state_d = IDLE;
        end else if (!bus.iwait) begin
          fill_en      = 1'b1;
          miss_count_d = sat_inc(miss_count_q);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      valid_d = '0;
    end else if (fill_en) begin
      valid_d[miss_idx] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      miss_addr_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      miss_addr_q  <= miss_addr_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag/data need no reset: a frame is only ever read behind its valid bit.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= bus.iload;
    end
  end

  assign bus.ihit       = ihit;
  assign bus.imemload   = imemload;
  assign bus.iREN       = iren;
  assign bus.iaddr      = iaddr;
  assign bus.miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed scenarios plus random traffic, all
// checked against a cache-contents model kept in the bench.
module tb_icache_responder;
  import icache_responder_pkg::*;

  localparam int SETS  = 16;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  icache_responder_if #(.CNT_W(CNT_W)) bus ();

  icache_responder #(.SETS(SETS), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Model: which word address each frame holds, plus the one pending fill.
  bit               m_valid [SETS];
  logic [29:0]      m_word  [SETS];
  bit               m_busy;
  word_t            m_addr;
  int               m_cnt;
  logic             cur_hit;
  logic             e_ihit;
  word_t            e_load;
  logic             e_iren;
  word_t            e_iaddr;
  logic [CNT_W-1:0] e_cnt;

  function automatic word_t mem_word(input word_t a);
    return ({a[31:2], 2'b00} ^ 32'h5A5A_1234) * 32'h0001_0003 + 32'h0000_0077;
  endfunction

  function automatic logic [69:0] got_v();
    return {bus.ihit, bus.imemload, bus.iREN, bus.iaddr, bus.miss_count};
  endfunction

  function automatic logic [69:0] want_v();
    return {e_ihit, e_load, e_iren, e_iaddr, e_cnt};
  endfunction

  function automatic string got_s();
    return $sformatf("ihit=%b load=%h iREN=%b iaddr=%h cnt=%0d",
                     bus.ihit, bus.imemload, bus.iREN, bus.iaddr, bus.miss_count);
  endfunction

  function automatic string want_s();
    return $sformatf("ihit=%b load=%h iREN=%b iaddr=%h cnt=%0d",
                     e_ihit, e_load, e_iren, e_iaddr, e_cnt);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    m_busy = 1'b0;
    m_addr = '0;
    m_cnt  = 0;
  endtask

  // Apply inputs for this cycle and derive what the cache must show.
  task automatic drive(input logic ren, input word_t addr, input logic fl, input logic iw);
    int idx;
    bus.imemREN  = ren;
    bus.imemaddr = addr;
    bus.flush    = fl;
    bus.iwait    = iw;
    bus.iload    = m_busy ? mem_word(m_addr) : (32'hBAD0_0000 ^ addr);
    #1;
    idx     = int'(addr[5:2]);
    cur_hit = !m_busy && ren && !fl && m_valid[idx] && (m_word[idx] == addr[31:2]);
    e_ihit  = cur_hit;
    e_load  = cur_hit ? mem_word(addr) : '0;
    e_iren  = m_busy;
    e_iaddr = m_busy ? m_addr : '0;
    e_cnt   = CNT_W'(m_cnt);
  endtask

  // Move the model across the coming clock edge, then wait for it.
  task automatic advance();
    int idx;
    if (bus.flush) begin
      for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (!bus.iwait) begin
        idx          = int'(m_addr[5:2]);
        m_valid[idx] = 1'b1;
        m_word[idx]  = m_addr[31:2];
        if (m_cnt < CMAX) m_cnt++;
        m_busy = 1'b0;
      end
    end else if (bus.imemREN && !cur_hit) begin
      m_busy = 1'b1;
      m_addr = bus.imemaddr & 32'hFFFF_FFFC;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    bus.imemREN = 1'b0; bus.imemaddr = '0; bus.flush = 1'b0;
    bus.iwait = 1'b1; bus.iload = '0;
    #1 RST = 1'b1;
    #1;
    checks++;
    if (got_v() !== 70'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %s want all zero", got_s());
    end
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_cold_miss();
    int iren_n = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 32'h0000_0040, 1'b0, (c >= 1 && c <= 3));
      checks++;
      if (got_v() !== want_v()) begin
        errors++; $display("FAIL cold_miss c%0d: got %s want %s", c, got_s(), want_s());
      end
      if (bus.iREN === 1'b1 && bus.iaddr === 32'h40) iren_n++;
      if (c == 5) begin
        checks++;
        if (bus.ihit !== 1'b1 || bus.imemload !== mem_word(32'h40) || bus.miss_count !== 4'd1) begin
          errors++; $display("FAIL cold_hit: got %s want ihit=1 load=%h cnt=1", got_s(), mem_word(32'h40));
        end
      end
      advance();
    end
    checks++;
    if (iren_n != 4) begin
      errors++; $display("FAIL cold_iren_cycles: got %0d want 4", iren_n);
    end
  endtask

  task automatic test_rehit();
    word_t addrs [2] = '{32'h0000_0040, 32'h0000_0042};
    foreach (addrs[k]) begin
      drive(1'b1, addrs[k], 1'b0, 1'b1);
      checks++;
      if (got_v() !== want_v()) begin
        errors++; $display("FAIL rehit %h: got %s want %s", addrs[k], got_s(), want_s());
      end
      checks++;
      if (bus.ihit !== 1'b1 || bus.iREN !== 1'b0 || bus.miss_count !== 4'd1) begin
        errors++; $display("FAIL rehit_direct %h: got %s want ihit=1 iREN=0 cnt=1", addrs[k], got_s());
      end
      advance();
    end
  endtask

  task automatic test_conflict();
    word_t addrs [2] = '{32'h0000_0080, 32'h0000_0040};
    foreach (addrs[k]) begin
      for (int c = 0; c < 3; c++) begin
        drive(1'b1, addrs[k], 1'b0, 1'b0);
        checks++;
        if (got_v() !== want_v()) begin
          errors++; $display("FAIL conflict %h c%0d: got %s want %s", addrs[k], c, got_s(), want_s());
        end
        if (c == 0) begin
          checks++;
          if (bus.ihit !== 1'b0) begin
            errors++; $display("FAIL conflict_miss %h: got ihit=%b want 0", addrs[k], bus.ihit);
          end
        end
        advance();
      end
    end
    checks++;
    if (bus.miss_count !== 4'd3) begin
      errors++; $display("FAIL conflict_count: got %0d want 3", bus.miss_count);
    end
  endtask

  task automatic test_redirect();
    word_t a   [8] = '{32'h100, 32'h200, 32'h200, 32'h100, 32'h200, 32'h200, 32'h200, 32'h100};
    logic  ren [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic  iw  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int c = 0; c < 8; c++) begin
      drive(ren[c], a[c], 1'b0, iw[c]);
      checks++;
      if (got_v() !== want_v()) begin
        errors++; $display("FAIL redirect c%0d: got %s want %s", c, got_s(), want_s());
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h100) begin
          errors++; $display("FAIL redirect_hold c%0d: got iREN=%b iaddr=%h want 1 00000100", c, bus.iREN, bus.iaddr);
        end
      end
      if (c == 3) begin
        checks++;
        if (bus.ihit !== 1'b1 || bus.imemload !== mem_word(32'h100)) begin
          errors++; $display("FAIL redirect_filled: got %s want ihit=1 load=%h", got_s(), mem_word(32'h100));
        end
      end
      if (c == 5) begin
        checks++;
        if (bus.iaddr !== 32'h200) begin
          errors++; $display("FAIL redirect_second: got iaddr=%h want 00000200", bus.iaddr);
        end
      end
      advance();
    end
  endtask

  task automatic test_flush_fill();
    logic [CNT_W-1:0] cnt0;
    word_t a  [6] = '{32'h48, 32'h48, 32'h40, 32'h40, 32'h40, 32'h48};
    logic  fl [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic  iw [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    cnt0 = bus.miss_count;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, a[c], fl[c], iw[c]);
      checks++;
      if (got_v() !== want_v()) begin
        errors++; $display("FAIL flush_fill c%0d: got %s want %s", c, got_s(), want_s());
      end
      if (c == 2) begin
        checks++;
        if (bus.ihit !== 1'b0 || bus.iREN !== 1'b0 || bus.miss_count !== cnt0) begin
          errors++; $display("FAIL flush_fill_abort: got %s want ihit=0 iREN=0 cnt=%0d", got_s(), cnt0);
        end
      end
      advance();
    end
    drive(1'b1, 32'h48, 1'b0, 1'b0);
    advance();
  endtask

  task automatic test_flush_idle();
    drive(1'b1, 32'h40, 1'b1, 1'b1);
    checks++;
    if (bus.ihit !== 1'b0 || bus.imemload !== 32'h0) begin
      errors++; $display("FAIL flush_idle_hit: got ihit=%b load=%h want 0 0", bus.ihit, bus.imemload);
    end
    advance();
    drive(1'b0, 32'h40, 1'b0, 1'b1);
    checks++;
    if (bus.iREN !== 1'b0 || got_v() !== want_v()) begin
      errors++; $display("FAIL flush_idle_nolatch: got %s want %s", got_s(), want_s());
    end
    advance();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < 2; c++) begin
        drive(1'b1, 32'h0000_1000 + 32'(i * 4), 1'b0, 1'b0);
        checks++;
        if (got_v() !== want_v()) begin
          errors++; $display("FAIL saturation i%0d c%0d: got %s want %s", i, c, got_s(), want_s());
        end
        advance();
      end
    end
    checks++;
    if (bus.miss_count !== 4'hF) begin
      errors++; $display("FAIL saturation_count: got %0d want 15", bus.miss_count);
    end
  endtask

  task automatic test_rst_mid_miss();
    drive(1'b1, 32'h0000_0300, 1'b0, 1'b1);
    advance();
    drive(1'b1, 32'h0000_0300, 1'b0, 1'b1);
    #2 RST = 1'b1;
    #1;
    checks++;
    if (got_v() !== 70'd0) begin
      errors++; $display("FAIL rst_mid_miss: got %s want all zero", got_s());
    end
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    drive(1'b1, 32'h0000_1004, 1'b0, 1'b1);
    checks++;
    if (bus.ihit !== 1'b0 || got_v() !== want_v()) begin
      errors++; $display("FAIL rst_first_access: got %s want %s", got_s(), want_s());
    end
    advance();
    drive(1'b1, 32'h0000_1004, 1'b0, 1'b0);
    checks++;
    if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h1004 || got_v() !== want_v()) begin
      errors++; $display("FAIL rst_refill: got %s want %s", got_s(), want_s());
    end
    advance();
  endtask

  task automatic test_random();
    word_t pool [8] = '{32'h40, 32'h80, 32'h44, 32'h100, 32'h200, 32'h3C, 32'h1040, 32'hFFFF_FFC0};
    word_t a;
    for (int c = 0; c < 400; c++) begin
      a = pool[$urandom_range(0, 7)] | word_t'($urandom_range(0, 3));
      drive(($urandom_range(0, 3) != 0), a, ($urandom_range(0, 29) == 0), $urandom_range(0, 1) != 0);
      checks++;
      if (got_v() !== want_v()) begin
        errors++; $display("FAIL random c%0d addr=%h: got %s want %s", c, a, got_s(), want_s());
      end
      advance();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cold_miss();
    test_rehit();
    test_conflict();
    test_redirect();
    test_flush_fill();
    test_flush_idle();
    test_saturation();
    test_rst_mid_miss();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
ICACHE_RESPONDER -- requirements
Module: icache_responder

Interface
REQ-001 Parameter SETS, default 16, number of direct-mapped one-word frames (power of two, 2..256).
REQ-002 Parameter CNT_W, default 16, width of the miss counter.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 imemREN  input  1  datapath instruction read request.
REQ-006 imemaddr  input  32  datapath instruction byte address (word_t).
REQ-007 ihit  output  1  requested word valid on imemload this cycle.
REQ-008 imemload  output  32  instruction word returned to datapath.
REQ-009 flush  input  1  invalidate all frames.
REQ-010 iREN  output  1  memory-side read request.
REQ-011 iaddr  output  32  memory-side word-aligned read address.
REQ-012 iwait  input  1  memory busy; iload valid in any cycle with iREN high and iwait low.
REQ-013 iload  input  32  memory-side read data.
REQ-014 miss_count  output  CNT_W  number of fills completed since reset.

Function
REQ-015 Address split: bits [1:0] byte offset ignored, next log2(SETS) bits index, remaining upper bits tag.
REQ-016 Each frame holds valid bit, tag, 32-bit data.
REQ-017 FSM states: IDLE, MISS.
REQ-018 IDLE: hit = imemREN and frame[index].valid and tag match; ihit = hit combinationally, imemload = frame data; zero-cycle hit latency.
REQ-019 IDLE with imemREN and no hit: latch word-aligned imemaddr as miss address, go to MISS next cycle; ihit low.
REQ-020 MISS: iREN high, iaddr = latched miss address, ihit low, regardless of current imemaddr.
REQ-021 MISS with iwait low: write iload, latched tag, valid=1 into frame at latched index; increment miss_count; return to IDLE.
REQ-022 Miss latency: requested word hits in the cycle after fill, i.e. memory latency + 1 cycles after miss detection.
REQ-023 imemaddr change or imemREN drop during MISS (branch redirect): fill still completes to latched address; IDLE then re-evaluates current address.
REQ-024 flush high: all valid bits cleared at next edge; in MISS, abort to IDLE, iREN low from next cycle, no frame written, miss_count unchanged.
REQ-025 flush coinciding with fill (MISS, iwait low): flush wins, no write, no count.
REQ-026 flush in IDLE: ihit forced low that cycle; no miss address latched.
REQ-027 miss_count saturates at all-ones; no wrap.
REQ-028 iREN low and iaddr = 0 in IDLE.
REQ-029 imemload = 0 whenever ihit low.

Reset
REQ-030 RST high: state IDLE, all valid bits 0, miss_count 0, miss address 0, immediately and without clock.
REQ-031 Outputs during reset: ihit 0, imemload 0, iREN 0, iaddr 0; tag/data arrays need not be cleared.
REQ-032 RST asserted mid-MISS: request abandoned, no frame written; first post-reset access misses.

Structure
REQ-033 word_t reuse from cpu_types_pkg; icache frame struct and state enum added to cpu_types_pkg.
REQ-034 Single module, no sub-modules; frame array as flops.

Verification
REQ-035 Cold read 0x00000040, iwait high 3 cycles -> iREN with iaddr 0x40 for 4 cycles, fill, ihit next cycle with stored word, miss_count 1.
REQ-036 Re-read 0x00000040, then 0x00000042 -> ihit same cycle both times, no iREN, miss_count 1.
REQ-037 Conflict: read 0x00000040 then 0x00000080 (SETS=16, same index) -> second misses and evicts; returning to 0x40 misses again, miss_count 3.
REQ-038 Redirect: miss on 0x100, imemaddr changes to 0x200 during MISS -> fill writes 0x100 frame, then 0x200 miss starts; later 0x100 hits.
REQ-039 flush during MISS with iwait low same cycle -> no write, IDLE next cycle, miss_count unchanged, prior hits now miss.
REQ-040 RST pulse mid-MISS (between edges) -> iREN low immediately, all lines invalid, miss_count 0.
